// File: rtl/meta_arb_rr_if.sv
// meta_arb_rr_if: N-channel slave metadata streams plus one tagged master stream.
// master modport: environment side (drives producer valid/data and consumer ready).
// slave modport: arbiter side (returns per-channel ready, drives m_meta_valid/data/id).
interface meta_arb_rr_if #(
  parameter int N_CH      = 4,
  parameter int DATA_BITS = 64,
  parameter int ID_BITS   = $clog2(N_CH)
);
  logic [N_CH-1:0]           s_meta_valid;
  logic [N_CH-1:0]           s_meta_ready;
  logic [N_CH*DATA_BITS-1:0] s_meta_data;
  logic                      m_meta_valid;
  logic                      m_meta_ready;
  logic [DATA_BITS-1:0]      m_meta_data;
  logic [ID_BITS-1:0]        m_meta_id;
  modport master (
    output s_meta_valid, s_meta_data, m_meta_ready,
    input  s_meta_ready, m_meta_valid, m_meta_data, m_meta_id
  );
  modport slave (
    input  s_meta_valid, s_meta_data, m_meta_ready,
    output s_meta_ready, m_meta_valid, m_meta_data, m_meta_id
  );
endinterface

// File: rtl/meta_arb_rr.sv
// meta_arb_rr: per-channel FIFOs round-robin arbitrated onto one registered, id-tagged stream.
// Ports: aclk, areset (async, active-high); bus (meta_arb_rr_if.slave) carries the N_CH slave
// streams and the master stream; stat_grant_cnt gives 32-bit per-channel grant counters.
// Optional macro META_ARB_STATS_EN enables the saturating grant counters; otherwise the port is 0.
module meta_arb_rr #(
  parameter int N_CH      = 4,
  parameter int DATA_BITS = 64,
  parameter int DEPTH     = 4,
  parameter int ID_BITS   = $clog2(N_CH)
) (
  input  logic                 aclk,
  input  logic                 areset,
  meta_arb_rr_if.slave         bus,
  output logic [N_CH*32-1:0]   stat_grant_cnt
);
  localparam int PW = $clog2(DEPTH);
  logic [N_CH-1:0]      push, pop, empty;
  logic [DATA_BITS-1:0] head [N_CH];
  logic [ID_BITS-1:0]   rr, gnt, j;
  logic                 gnt_v, load_en;
  logic                 mv;
  logic [DATA_BITS-1:0] md;
  logic [ID_BITS-1:0]   mid;
  assign load_en = !mv || bus.m_meta_ready;
  assign push    = bus.s_meta_valid & bus.s_meta_ready;
  assign pop     = (load_en && gnt_v) ? (N_CH'(1) << gnt) : '0;
  // Walk downward so the channel closest after rr is the last, winning assignment.
  always_comb begin
    gnt_v = 1'b0;
    gnt   = '0;
    j     = '0;
    for (int k = N_CH; k >= 1; k--) begin
      j = ID_BITS'((int'(rr) + k) % N_CH);
      if (!empty[j]) begin
        gnt_v = 1'b1;
        gnt   = j;
      end
    end
  end
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [PW-1:0]        wp, rp;
    logic [PW:0]          cnt, cnt_nxt;
    logic                 rdy;
    assign cnt_nxt = cnt + (PW+1)'(push[c]) - (PW+1)'(pop[c]);
    assign empty[c] = (cnt == '0);
    assign head[c] = mem[rp];
    assign bus.s_meta_ready[c] = rdy;
    always_ff @(posedge aclk or posedge areset)
      if (areset) begin
        wp  <= '0;
        rp  <= '0;
        cnt <= '0;
        rdy <= 1'b0;
      end else begin
        wp  <= wp + PW'(push[c]);
        rp  <= rp + PW'(pop[c]);
        cnt <= cnt_nxt;
        rdy <= cnt_nxt != (PW+1)'(DEPTH);
      end
    always_ff @(posedge aclk)
      if (push[c]) mem[wp] <= bus.s_meta_data[c*DATA_BITS +: DATA_BITS];
`ifdef META_ARB_STATS_EN
    logic [31:0] sc;
    always_ff @(posedge aclk or posedge areset)
      if (areset) sc <= '0;
      else if (pop[c] && sc != 32'hFFFF_FFFF) sc <= sc + 32'd1;
    assign stat_grant_cnt[c*32 +: 32] = sc;
`endif
  end
`ifndef META_ARB_STATS_EN
  assign stat_grant_cnt = '0;
`endif
  always_ff @(posedge aclk or posedge areset)
    if (areset) begin
      mv  <= 1'b0;
      md  <= '0;
      mid <= '0;
      rr  <= ID_BITS'(N_CH - 1);
    end else if (load_en) begin
      mv <= gnt_v;
      if (gnt_v) begin
        md  <= head[gnt];
        mid <= gnt;
        rr  <= gnt;
      end
    end
  assign bus.m_meta_valid = mv;
  assign bus.m_meta_data  = md;
  assign bus.m_meta_id    = mid;
endmodule

// File: doc/meta_arb_rr.md
Name: meta_arb_rr

Overview:
- N-channel metadata aggregator for the RoCE stack.
- Gathers valid/ready/data metadata streams (same handshake as the generic meta interface) from N_CH producers, for example per-QP request generators.
- Buffers each channel in a small FIFO and round-robin arbitrates them onto one registered master stream, tagging each beat with its source channel id.
- Successor to the single-channel meta channel: parametrised in width, depth and channel count, with buffering and fair arbitration.

Parameters:
- N_CH, 4: number of slave channels; range 2..16.
- DATA_BITS, 64: metadata payload width per channel.
- DEPTH, 4: per-channel FIFO depth; power of two, ≥2.
- ID_BITS, $clog2(N_CH): width of the channel id tag.

Ports:
- aclk  in  1  clock; all logic on rising edge.
- areset  in  1  asynchronous, active-high reset.
- s_meta_valid  in  N_CH  per-channel valid.
- s_meta_ready  out  N_CH  per-channel ready.
- s_meta_data  in  N_CH*DATA_BITS  channel i occupies bits [i*DATA_BITS +: DATA_BITS].
- m_meta_valid  out  1  output valid.
- m_meta_ready  in  1  output ready.
- m_meta_data  out  DATA_BITS  granted payload.
- m_meta_id  out  ID_BITS  source channel of m_meta_data.
- stat_grant_cnt  out  N_CH*32  per-channel grant counters (optional feature).

Behaviour:
- Reset (areset high, asynchronous): all FIFOs empty, pointers and counts 0, s_meta_ready = 0 while areset is high, m_meta_valid = 0, m_meta_data = 0, m_meta_id = 0, rr pointer = N_CH-1 (so channel 0 has first priority), stat counters 0.
  - Mid-operation reset discards all buffered beats immediately.
  - s_meta_ready rises on the first edge after release.
- Per-channel FIFO:
  - wr/rd pointers are log2(DEPTH) bits and wrap naturally.
  - Occupancy count is log2(DEPTH)+1 bits.
  - s_meta_ready[i] = !full[i], registered from the count; ready does not depend on same-cycle pop.
  - Push when s_meta_valid[i] && s_meta_ready[i].
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Push is never accepted when full. Data is held by the producer per handshake rules.
- Output stage: single register (m_meta_valid/data/id).
  - load_en = !m_meta_valid || m_meta_ready.
  - When load_en and at least one FIFO is non-empty: grant the first non-empty channel searching from (rr+1) mod N_CH upward with wrap; pop that FIFO; load its head into data and its index into id; set m_meta_valid; rr := granted index.
  - When load_en and all FIFOs are empty: m_meta_valid := 0. data and id hold their last value.
  - While m_meta_valid && !m_meta_ready: data and id stay stable and no pop occurs (AXI-stream rule).
- Latency:
  - A beat accepted at edge t into an empty block with an empty output is visible on m_meta_valid after edge t+1.
  - No combinational path from s_* to m_*.
- Throughput: one beat per cycle sustained while m_meta_ready is held high and any FIFO is non-empty.
- Fairness: with all channels continuously backlogged, grants cycle 0,1,...,N_CH-1,0,...
  - No channel waits more than N_CH-1 grants once its FIFO is non-empty.
- Ordering: per-channel order is preserved. There is no ordering guarantee across channels.

Optional Feature:
- Macro: META_ARB_STATS_EN.
- Defined:
  - stat_grant_cnt[i*32 +: 32] increments by 1 on each grant to channel i.
  - Saturates at 32'hFFFF_FFFF.
  - Cleared by areset only.
- Not defined: stat_grant_cnt is driven constant 0 and no counter flops are synthesised.

Test Plan:
- Reset/idle: hold areset 3 cycles, then release → s_meta_ready = 4'b1111 from the first edge after release; m_meta_valid = 0, m_meta_id = 0.
- Single beat: ch2 pushes 64'hDEAD_BEEF at edge t, m_meta_ready = 1 → m_meta_valid = 1, data = 64'hDEAD_BEEF, id = 2 after edge t+1; valid = 0 the next cycle.
- Round-robin: all 4 channels preload 2 beats each (ch i data = 16*i+k), then m_meta_ready = 1 → id sequence 0,1,2,3,0,1,2,3; data in per-channel order, e.g. ch1 yields 16 then 17.
- Full/backpressure: m_meta_ready = 0, ch0 pushes 6 beats:
  - 4 are accepted into the FIFO and 1 is loaded into the output register.
  - s_meta_ready[0] = 0 after the FIFO refills to 4.
  - Data stays stable.
  - Releasing ready drains all 5 in order with no loss or duplication.
- Mid-operation reset: assert areset asynchronously with 3 beats buffered → m_meta_valid drops without waiting for an edge. After release, no stale beat appears and arbitration restarts at ch0.
- Stats (META_ARB_STATS_EN): 5 grants to ch3 and 2 to ch0 → stat_grant_cnt ch3 field = 5, ch0 field = 2, others 0. Without the macro, the port reads 0.
